// File: rtl/count01_pkg.sv
// Shared types and defaults for the count01 round-robin scheduler.
package count01_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;

    typedef struct packed {
        logic v;
        logic p;
    } hist_t;

    typedef logic [$clog2(NCH_DEF)-1:0] ch_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the channel after the last winner.
module rr_arbiter
    import count01_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt
);

    localparam int CHW = $clog2(NCH);

    logic [CHW-1:0] last;
    logic [CHW-1:0] cand;
    logic [CHW-1:0] gidx;
    logic           found;

    // Walk last+1 .. last+NCH and keep the first requester; gnt never sees x.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CHW'((int'(last) + k) % NCH);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
        end
        if (rst) begin
            gnt = '0;
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                gidx = CHW'(i);
            end
        end
    end

    // Reset parks the pointer on the top channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= CHW'(NCH - 1);
        end else if (|gnt) begin
            last <= gidx;
        end
    end

endmodule

// File: rtl/count01_sched.sv
// Shares one "01" detector among NCH serial streams, saving {v,p} per stream
// and keeping a wrapping hit counter per channel.
module count01_sched
    import count01_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         x,
    input  logic [NCH-1:0]         clr,
    output logic [NCH-1:0]         gnt,
    output logic                   z,
    output logic [$clog2(NCH)-1:0] z_ch,
    input  logic [$clog2(NCH)-1:0] rd_sel,
    output logic [CW-1:0]          rd_cnt
);

    localparam int CHW = $clog2(NCH);

    // Handshake: a requester holds req[i] and x[i] until it sees gnt[i]; the
    // bit is transferred at the rising edge where gnt[i] is 1.

    hist_t          hist [NCH];
    logic [CW-1:0]  cnt  [NCH];
    logic [CHW-1:0] gidx;
    logic           hit;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                gidx = CHW'(i);
            end
        end
    end

    // A clear on the granted channel suppresses the hit for that cycle.
    assign hit = (|gnt) && !clr[gidx] && hist[gidx].v && !hist[gidx].p && x[gidx];

    always_ff @(posedge clk) begin
        if (rst) begin
            z    <= 1'b0;
            z_ch <= '0;
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            z <= hit;
            if (hit) begin
                z_ch <= gidx;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    hist[i] <= '0;
                    cnt[i]  <= '0;
                end else if (gnt[i]) begin
                    hist[i].v <= 1'b1;
                    hist[i].p <= x[i];
                    if (hit) begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign rd_cnt = cnt[rd_sel];

endmodule

// File: doc/count01_sched.md
# count01_sched

Round-robin scheduler that shares a single "01" pattern-detector datapath among NCH serial bit streams. Each stream's 2-bit detector state is saved and restored per grant, so every stream behaves as if it owned its own `count01`. Hits are reported as a registered pulse tagged with the channel, and each channel keeps a wrapping hit counter. The block sits between the serial input requesters and the downstream result consumers.

## Interface
- `NCH`, 4: number of requesting streams (2..8).
- `CW`, 8: width of each per-channel hit counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req`  in  NCH  per-channel request. Requester holds `req[i]` and `x[i]` stable until it sees `gnt[i]`.
- `x`  in  NCH  per-channel serial bit offered with `req[i]`.
- `clr`  in  NCH  per-channel synchronous clear of history and hit counter.
- `gnt`  out  NCH  one-hot grant, combinational from `req` and the pointer. `x[i]` is consumed at the edge where `gnt[i]` is 1.
- `z`  out  1  registered hit pulse.
- `z_ch`  out  $clog2(NCH)  channel that produced `z`. Valid only when `z` is 1.
- `rd_sel`  in  $clog2(NCH)  counter read select.
- `rd_cnt`  out  CW  combinational read of the hit counter selected by `rd_sel`.

## Operation
- Per-channel saved state `{v, p}`:
  - `v`: a previous bit exists.
  - `p`: the previous accepted bit.
  - Reset value is `{0,0}`.
- Arbitration:
  - Pointer `last` holds the most recently granted channel.
  - Search order is `last+1, last+2, …` modulo NCH.
  - The first requesting channel in that order gets the grant.
  - No request means `gnt` is 0, the pointer is held and there is no state change.
- On grant of channel `c` with bit `b`:
  - hit = `v[c] & ~p[c] & b`.
  - Next `{v[c], p[c]}` = `{1, b}`.
  - `last` becomes `c`.
- Hit:
  - `z` = 1 and `z_ch` = `c` in the next cycle.
  - `cnt[c]` increments, wrapping from 2^CW−1 to 0.
  - Patterns overlap: stream 0,1,0,1 yields two hits.
- `clr[i]`:
  - Next `{v, p}` for channel i is `{0,0}` and `cnt[i]` becomes 0.
  - If `clr[i]` and `gnt[i]` occur in the same cycle, clear wins: no hit is counted or pulsed, and the history is not updated.
  - `clr` never blocks arbitration.
- Non-hit grant: `z` = 0 next cycle.
- `z` is a single-cycle pulse per hit. Back-to-back hits on different channels give consecutive `z` pulses.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge):
  - All `{v, p}` are 0, all `cnt` are 0, `z` = 0, `z_ch` = 0.
  - `last` = NCH−1, so channel 0 has first priority after reset.
  - `gnt` is forced to 0 while `rst` = 1.
- Reset mid-operation discards the in-flight grant: no `z` next cycle and no counter update.
- Throughput is one bit per cycle across all channels.
- With all NCH requesting, each channel is served once every NCH cycles.
- Latency from grant edge to `z`/`z_ch` is 1 cycle.
- Latency from grant edge to the updated `rd_cnt` is 1 cycle.
- `gnt` depends combinationally on `req` only. There is no path from `x` to `gnt`.

## Structure
- Package `count01_pkg`:
  - `NCH` and `CW` defaults.
  - `typedef struct packed {logic v; logic p;} hist_t`.
  - Channel-index type `ch_t`.
- Sub-module `rr_arbiter`:
  - Parameter NCH; ports `clk`, `rst`, `req`, `gnt`.
  - Owns `last` and the rotate/priority search.
- The top level holds the `hist_t` array, the hit logic, the counters, the `z`/`z_ch` registers and the read mux.

## Test plan
- Reset then single channel: `req[0]`=1, x = 0,0,1,0,0,0,1,1,1,0,1,1,0,0 → `z` pulses exactly 3 times (after the 3rd, 7th and 11th bit) with `z_ch`=0; `rd_cnt`(sel 0) = 3.
- Interleaving isolation: all 4 requesting every cycle; ch0 sends 0,1, ch1 sends 1,0, ch2 sends 0,0, ch3 sends 0,1 → grants go 0,1,2,3,0,1,2,3; hits only on ch0 and ch3, on the second lap; counters 1,0,0,1.
- Fairness: `req` = 4'b1010 held for 8 cycles after reset → `gnt` alternates 0010, 1000, and no channel is starved.
- Clear collision: ch2 history = 0, then `gnt[2]` with x=1 and `clr[2]`=1 in the same cycle → `z`=0 and `cnt[2]`=0; the next `0,1` on ch2 produces a hit.
- Wrap: CW=2, drive 5 hits on ch1 → `rd_cnt` reads 1,2,3,0,1.
- Reset mid-stream: ch0 has history 0 and is granted x=1 in the cycle where `rst`=1 → no `z`, counters 0, and the next x=1 on ch0 does not hit, because `v` was cleared.
